// File: rtl/lc3_controller.sv
// Pipeline controller for a five-stage LC-3: sequences stage enables through fill, memory, branch-stall and I-miss states.
// All outputs are registered from next-state logic, so no input reaches an output in the same cycle.
module lc3_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic [15:0] ir_exec,
  input  logic [2:0]  nzp,
  input  logic        complete_instr,
  input  logic        complete_data,
  output logic        enable_fetch,
  output logic        enable_updatePC,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic [1:0]  mem_state
);

  typedef enum logic [2:0] {FILL, RUN, MEM, BR_STALL, IMISS} state_t;

  localparam logic [1:0] MS_READ = 2'd0;
  localparam logic [1:0] MS_IND  = 2'd1;
  localparam logic [1:0] MS_WR   = 2'd2;
  localparam logic [1:0] MS_IDLE = 2'd3;

  // enable vector order: {fetch, updatePC, decode, execute, writeback}
  state_t     r_state, w_state;
  logic [1:0] r_fill, w_fill;
  logic       r_br_ph, w_br_ph;
  logic       r_br_jmp, w_br_jmp;
  logic       r_mem_wr, w_mem_wr;
  logic [4:0] r_en, w_en;
  logic       r_br_taken, w_br_taken;
  logic [1:0] r_mem_state, w_mem_state;

  logic [3:0] w_ir_op;
  logic [3:0] w_ex_op;
  logic       w_ex_mem;
  logic       w_ex_wr;
  logic [1:0] w_ex_ms;
  logic       w_ir_br;
  logic       w_ir_jmp;
  logic       w_unused;

  assign w_ir_op  = ir[15:12];
  assign w_ex_op  = ir_exec[15:12];
  assign w_ir_br  = (w_ir_op == 4'b0000);
  assign w_ir_jmp = (w_ir_op == 4'b1100);
  assign w_unused = &{1'b0, ir[11:0], ir_exec[8:0]};

  always_comb begin
    w_ex_mem = 1'b1;
    w_ex_wr  = 1'b0;
    w_ex_ms  = MS_IDLE;
    case (w_ex_op)
      4'b0010, 4'b0110: w_ex_ms = MS_READ;
      4'b1010:          w_ex_ms = MS_IND;
      4'b0011, 4'b0111: begin w_ex_ms = MS_WR;  w_ex_wr = 1'b1; end
      4'b1011:          begin w_ex_ms = MS_IND; w_ex_wr = 1'b1; end
      default:          w_ex_mem = 1'b0;
    endcase
  end

  always_comb begin
    w_state     = r_state;
    w_fill      = r_fill;
    w_br_ph     = r_br_ph;
    w_br_jmp    = r_br_jmp;
    w_mem_wr    = r_mem_wr;
    w_en        = r_en;
    w_br_taken  = 1'b0;
    w_mem_state = MS_IDLE;
    case (r_state)
      FILL: begin
        w_fill = r_fill + 2'd1;
        case (r_fill)
          2'd0:    w_en = 5'b11000;
          2'd1:    w_en = 5'b11100;
          2'd2:    w_en = 5'b11110;
          default: begin w_en = 5'b11111; w_state = RUN; end
        endcase
      end
      RUN: begin
        // memory op in execute wins; a pending branch is seen again after MEM
        if (w_ex_mem) begin
          w_state     = MEM;
          w_en        = 5'b00000;
          w_mem_state = w_ex_ms;
          w_mem_wr    = w_ex_wr;
        end else if (w_ir_br || w_ir_jmp) begin
          w_state  = BR_STALL;
          w_br_ph  = 1'b0;
          w_br_jmp = w_ir_jmp;
          w_en     = 5'b00011;
        end else if (!complete_instr) begin
          w_state = IMISS;
          w_en    = 5'b00000;
        end else begin
          w_en = 5'b11111;
        end
      end
      MEM: begin
        w_en        = 5'b00000;
        w_mem_state = r_mem_state;
        if (complete_data) begin
          if (r_mem_state == MS_IND) begin
            w_mem_state = r_mem_wr ? MS_WR : MS_READ;
          end else begin
            // stores have nothing to write back on the exit cycle
            w_state     = RUN;
            w_mem_state = MS_IDLE;
            w_en        = r_mem_wr ? 5'b11110 : 5'b11111;
          end
        end
      end
      BR_STALL: begin
        if (!r_br_ph) begin
          w_br_ph    = 1'b1;
          w_en       = 5'b01011;
          w_br_taken = r_br_jmp | (|(ir_exec[11:9] & nzp));
        end else begin
          w_state = RUN;
          w_en    = 5'b11111;
        end
      end
      IMISS: begin
        w_en = 5'b00000;
        if (complete_instr) begin
          w_state = RUN;
          w_en    = 5'b11111;
        end
      end
      default: begin
        w_state = FILL;
        w_fill  = 2'd0;
        w_en    = 5'b00000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= FILL;
      r_fill      <= 2'd0;
      r_br_ph     <= 1'b0;
      r_br_jmp    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_en        <= 5'b00000;
      r_br_taken  <= 1'b0;
      r_mem_state <= MS_IDLE;
    end else begin
      r_state     <= w_state;
      r_fill      <= w_fill;
      r_br_ph     <= w_br_ph;
      r_br_jmp    <= w_br_jmp;
      r_mem_wr    <= w_mem_wr;
      r_en        <= w_en;
      r_br_taken  <= w_br_taken;
      r_mem_state <= w_mem_state;
    end
  end

  assign enable_fetch     = r_en[4];
  assign enable_updatePC  = r_en[3];
  assign enable_decode    = r_en[2];
  assign enable_execute   = r_en[1];
  assign enable_writeback = r_en[0];
  assign br_taken         = r_br_taken;
  assign mem_state        = r_mem_state;

endmodule

// File: tb/tb_lc3_controller.sv
// Directed bench for lc3_controller: driver queues the expected output word per cycle, monitor pops and compares.
// Word layout: {fetch, updatePC, decode, execute, writeback, br_taken, mem_state[1:0]}.
module tb_lc3_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir, ir_exec;
  logic [2:0]  nzp;
  logic        complete_instr, complete_data;
  logic        enable_fetch, enable_updatePC, enable_decode, enable_execute, enable_writeback;
  logic        br_taken;
  logic [1:0]  mem_state;

  lc3_controller dut (
    .clk(clk), .rst(rst), .ir(ir), .ir_exec(ir_exec), .nzp(nzp),
    .complete_instr(complete_instr), .complete_data(complete_data),
    .enable_fetch(enable_fetch), .enable_updatePC(enable_updatePC),
    .enable_decode(enable_decode), .enable_execute(enable_execute),
    .enable_writeback(enable_writeback), .br_taken(br_taken), .mem_state(mem_state)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] E_RST  = 8'b00000_0_11;
  localparam logic [7:0] E_F1   = 8'b11000_0_11;
  localparam logic [7:0] E_F2   = 8'b11100_0_11;
  localparam logic [7:0] E_F3   = 8'b11110_0_11;
  localparam logic [7:0] E_RUN  = 8'b11111_0_11;
  localparam logic [7:0] E_OFF  = 8'b00000_0_11;
  localparam logic [7:0] E_MRD  = 8'b00000_0_00;
  localparam logic [7:0] E_MIND = 8'b00000_0_01;
  localparam logic [7:0] E_MWR  = 8'b00000_0_10;
  localparam logic [7:0] E_WEX  = 8'b11110_0_11;
  localparam logic [7:0] E_BS1  = 8'b00011_0_11;
  localparam logic [7:0] E_BS2T = 8'b01011_1_11;
  localparam logic [7:0] E_BS2N = 8'b01011_0_11;
  localparam logic [15:0] NOP = 16'h1000;

  logic [7:0] exp_q[$];
  string      name_q[$];
  int         checks = 0;
  int         errors = 0;

  task automatic cyc(input logic [7:0] exp, input string name);
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    logic [7:0] act, exp;
    string      nm;
    #1;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {enable_fetch, enable_updatePC, enable_decode, enable_execute,
             enable_writeback, br_taken, mem_state};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: got %b required %b", nm, act, exp);
      end
    end
  end

  task automatic branch(input logic [15:0] instr, input logic [2:0] cc,
                        input logic [7:0] exp2, input string name);
    ir = instr; ir_exec = instr; nzp = cc;
    cyc(E_BS1, {name, "_bs1"});
    ir = NOP;
    cyc(exp2, {name, "_bs2"});
    ir_exec = NOP;
    cyc(E_RUN, {name, "_run"});
  endtask

  initial begin
    rst = 1'b0; ir = NOP; ir_exec = NOP; nzp = 3'b000;
    complete_instr = 1'b1; complete_data = 1'b0;
    repeat (2) @(negedge clk);
    cyc(E_RST, "reset");

    rst = 1'b1;
    cyc(E_F1, "fill1");
    cyc(E_F2, "fill2");
    cyc(E_F3, "fill3");
    cyc(E_RUN, "fill4");
    complete_data = 1'b1;
    cyc(E_RUN, "run_ignore_cd");
    complete_data = 1'b0;

    // LDI: indirect read, then read, then writeback exit
    ir_exec = 16'hA000;
    cyc(E_MIND, "ldi_ind0");
    ir_exec = NOP;
    cyc(E_MIND, "ldi_ind1");
    cyc(E_MIND, "ldi_ind2");
    complete_data = 1'b1; cyc(E_MRD, "ldi_rd0");
    complete_data = 1'b0; cyc(E_MRD, "ldi_rd1");
    cyc(E_MRD, "ldi_rd2");
    complete_data = 1'b1; cyc(E_RUN, "ldi_exit");
    complete_data = 1'b0; cyc(E_RUN, "ldi_run");

    // LD: single read
    ir_exec = 16'h2000;
    cyc(E_MRD, "ld_rd");
    ir_exec = NOP; complete_data = 1'b1;
    cyc(E_RUN, "ld_exit");
    complete_data = 1'b0;

    branch(16'h0400, 3'b010, E_BS2T, "br_z_taken");
    branch(16'h0400, 3'b100, E_BS2N, "br_z_not");
    branch(16'h0000, 3'b111, E_BS2N, "br_000");
    branch(16'h0E00, 3'b001, E_BS2T, "br_111");

    // JMP in decode with STR in execute: memory first, then branch stall
    ir = 16'hC000; ir_exec = 16'h7000;
    cyc(E_MWR, "str_wr0");
    ir_exec = NOP;
    cyc(E_MWR, "str_wr1");
    complete_data = 1'b1; cyc(E_WEX, "str_exit");
    complete_data = 1'b0; cyc(E_BS1, "jmp_bs1");
    ir = NOP;             cyc(E_BS2T, "jmp_bs2");
    cyc(E_RUN, "jmp_run");

    // instruction miss for two cycles
    complete_instr = 1'b0;
    cyc(E_OFF, "imiss0");
    cyc(E_OFF, "imiss1");
    complete_instr = 1'b1;
    cyc(E_RUN, "imiss_exit");

    // reset in the middle of an indirect access
    ir_exec = 16'hA000;
    cyc(E_MIND, "rst_mem0");
    ir_exec = NOP;
    cyc(E_MIND, "rst_mem1");
    rst = 1'b0; complete_data = 1'b1;
    #1;
    checks++;
    if ({enable_fetch, enable_updatePC, enable_decode, enable_execute,
         enable_writeback, br_taken, mem_state} !== E_RST) begin
      errors++;
      $display("FAIL rst_async: got %b required %b",
               {enable_fetch, enable_updatePC, enable_decode, enable_execute,
                enable_writeback, br_taken, mem_state}, E_RST);
    end
    @(negedge clk);
    cyc(E_RST, "rst_hold");
    rst = 1'b1; complete_data = 1'b0;
    cyc(E_F1, "refill1");
    cyc(E_F2, "refill2");
    cyc(E_F3, "refill3");
    cyc(E_RUN, "refill4");
    cyc(E_RUN, "refill_run");

    repeat (20) begin
      if (exp_q.size() != 0) @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running required finished");
    $fatal(1);
  end

endmodule
